jtframe_ddram_resp: RTL and testbench

- Synthesizable responder for the DDRAM request interface used by the line/frame buffer controllers; it acts as the memory side.
- Backed by on-chip block RAM, so frame-buffer cores can run and be verified on boards and benches without DDR3.
- Returns read bursts after a configurable latency and can inject periodic busy stalls to exercise initiator hold logic.
- Provides a small status window on the common st_addr/st_dout bus.

---
 rtl/jtframe_ddram_pkg.sv | 21 ++
 rtl/jtframe_ddram_resp_mem.sv | 28 ++
 rtl/jtframe_ddram_resp.sv | 172 +++++++++++++++++
 tb/tb_jtframe_ddram_resp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_ddram_pkg.sv
// Shared encodings for the DDRAM block-RAM responder.
package jtframe_ddram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD      = 2'd3
  } state_t;

  localparam logic [7:0] ST_RDCNT = 8'd0;
  localparam logic [7:0] ST_WRCNT = 8'd1;
  localparam logic [7:0] ST_ERR   = 8'd2;
  localparam logic [7:0] ST_STATE = 8'd3;

  // Beats still to go after the first one; a zero burst count behaves as one beat.
  function automatic logic [7:0] beats_left(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/jtframe_ddram_resp_mem.sv
// Single-port 64-bit RAM with byte write enables and registered read data.
module jtframe_ddram_resp_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [63:0]   din_i,
  output logic [63:0]   dout_o
);

  logic [63:0] ram [0:(1<<AW)-1];
  logic [63:0] dout_q;

  // Byte-masked write and one-cycle read on the same port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) ram[addr_i][i*8 +: 8] <= din_i[i*8 +: 8];
      end
    end
    dout_q <= ram[addr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/jtframe_ddram_resp.sv
// Memory-side responder for the DDRAM request bus, backed by block RAM.
//
// state   | meaning
// IDLE    | waiting for a read or the first write beat
// WR      | collecting the remaining beats of a write burst
// RD_WAIT | latency countdown before the first read beat
// RD      | streaming one read beat per cycle
module jtframe_ddram_resp
  import jtframe_ddram_pkg::*;
#(
  parameter int AW       = 12,
  parameter int LATENCY  = 4,
  parameter int BUSY_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ddram_busy,
  input  logic [7:0]  ddram_burstcnt,
  input  logic [28:0] ddram_addr,
  input  logic        ddram_rd,
  input  logic        ddram_we,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  input  logic [7:0]  st_addr,
  output logic [7:0]  st_dout
);

  localparam logic [3:0]    WAIT_LOAD  = 4'(LATENCY - 2);
  localparam logic [15:0]   GAP_RELOAD = (BUSY_GAP > 0) ? 16'(BUSY_GAP - 1) : 16'd0;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    remain_q, remain_d;
  logic [3:0]    wait_q, wait_d;
  logic [15:0]   gap_q;
  logic          rst_q;
  logic [7:0]    rdcnt_q, rdcnt_d;
  logic [7:0]    wrcnt_q, wrcnt_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    st_q, st_d;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;
  logic          inject;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_rdata;
  logic          unused_addr;

  // Only the low AW address bits select a word; the rest are ignored.
  assign unused_addr = ^ddram_addr[28:AW];

  // Busy: held through reset and its release cycle, during reads, and on injected stalls.
  always_comb begin
    inject = (BUSY_GAP != 0) && (gap_q == 16'd0) && (state_q == IDLE || state_q == WR);
    busy   = rst | rst_q | inject | (state_q == RD_WAIT) | (state_q == RD);
  end

  // Next-state, address pointer, beat/latency counters and bookkeeping.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    wait_d   = wait_q;
    rdcnt_d  = rdcnt_q;
    wrcnt_d  = wrcnt_q;
    err_inc  = 2'd0;
    mem_we   = 1'b0;
    mem_addr = ptr_q;
    case (state_q)
      IDLE: begin
        mem_addr = ddram_addr[AW-1:0];
        if (ddram_we && !busy) begin
          mem_we   = 1'b1;
          wrcnt_d  = wrcnt_q + 8'd1;
          ptr_d    = ddram_addr[AW-1:0] + PTR_ONE;
          remain_d = beats_left(ddram_burstcnt);
          if (ddram_burstcnt > 8'd1) state_d = WR;
          if (ddram_rd) err_inc = err_inc + 2'd1;
          if (ddram_burstcnt == 8'd0) err_inc = err_inc + 2'd1;
        end else if (ddram_rd && !busy) begin
          rdcnt_d  = rdcnt_q + 8'd1;
          ptr_d    = ddram_addr[AW-1:0];
          remain_d = beats_left(ddram_burstcnt);
          wait_d   = WAIT_LOAD;
          state_d  = RD_WAIT;
          if (ddram_burstcnt == 8'd0) err_inc = err_inc + 2'd1;
        end
      end
      WR: begin
        if (ddram_rd && !busy) err_inc = err_inc + 2'd1;
        if (ddram_we && !busy) begin
          mem_we   = 1'b1;
          ptr_d    = ptr_q + PTR_ONE;
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // The RAM is addressed with beat 0 here so its data lands with the RD entry.
        if (wait_q == 4'd0) state_d = RD;
        else wait_d = wait_q - 4'd1;
      end
      RD: begin
        // Prefetch the following word while the current one is on the bus.
        mem_addr = ptr_q + PTR_ONE;
        ptr_d    = ptr_q + PTR_ONE;
        if (remain_q == 8'd0) state_d = IDLE;
        else remain_d = remain_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Status window select.
  always_comb begin
    case (st_addr)
      ST_RDCNT: st_d = rdcnt_q;
      ST_WRCNT: st_d = wrcnt_q;
      ST_ERR:   st_d = err_q;
      ST_STATE: st_d = {6'd0, state_q};
      default:  st_d = 8'd0;
    endcase
  end

  // State and counter registers; the stall counter free-runs and reloads at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      remain_q <= 8'd0;
      wait_q   <= 4'd0;
      gap_q    <= 16'd0;
      rst_q    <= 1'b1;
      rdcnt_q  <= 8'd0;
      wrcnt_q  <= 8'd0;
      err_q    <= 8'd0;
      st_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      wait_q   <= wait_d;
      gap_q    <= (gap_q == 16'd0) ? GAP_RELOAD : gap_q - 16'd1;
      rst_q    <= 1'b0;
      rdcnt_q  <= rdcnt_d;
      wrcnt_q  <= wrcnt_d;
      err_q    <= err_d;
      st_q     <= st_d;
    end
  end

  jtframe_ddram_resp_mem #(.AW(AW)) u_mem (
    .clk    (clk),
    .addr_i (mem_addr),
    .we_i   (mem_we),
    .be_i   (ddram_be),
    .din_i  (ddram_din),
    .dout_o (mem_rdata)
  );

  assign ddram_busy       = busy;
  assign ddram_dout_ready = (state_q == RD);
  assign ddram_dout       = (state_q == RD) ? mem_rdata : 64'd0;
  assign st_dout          = st_q;

endmodule

// File: tb/tb_jtframe_ddram_resp.sv
// Directed bench for jtframe_ddram_resp: one instance without stalls, one with BUSY_GAP=5.
module tb_jtframe_ddram_resp;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel    = 1'b0;
  logic        q_rd   = 1'b0;
  logic        q_we   = 1'b0;
  logic [28:0] q_addr = '0;
  logic [7:0]  q_cnt  = '0;
  logic [7:0]  q_be   = '0;
  logic [7:0]  q_st   = '0;
  logic [63:0] q_din  = '0;

  logic        a_busy, b_busy, a_rdy, b_rdy;
  logic [63:0] a_dout, b_dout;
  logic [7:0]  a_st, b_st;

  wire         busy_s = sel ? b_busy : a_busy;
  wire         rdy_s  = sel ? b_rdy  : a_rdy;
  wire  [63:0] dout_s = sel ? b_dout : a_dout;
  wire  [7:0]  st_s   = sel ? b_st   : a_st;

  int checks   = 0;
  int failures = 0;

  logic [63:0] wdata [0:31];
  logic [63:0] edata [0:31];

  jtframe_ddram_resp #(.AW(12), .LATENCY(LAT), .BUSY_GAP(0)) dut (
    .clk              (clk),
    .rst              (rst),
    .ddram_busy       (a_busy),
    .ddram_burstcnt   (q_cnt),
    .ddram_addr       (q_addr),
    .ddram_rd         (q_rd & ~sel),
    .ddram_we         (q_we & ~sel),
    .ddram_din        (q_din),
    .ddram_be         (q_be),
    .ddram_dout       (a_dout),
    .ddram_dout_ready (a_rdy),
    .st_addr          (q_st),
    .st_dout          (a_st)
  );

  jtframe_ddram_resp #(.AW(12), .LATENCY(LAT), .BUSY_GAP(5)) dut_gap (
    .clk              (clk),
    .rst              (rst),
    .ddram_busy       (b_busy),
    .ddram_burstcnt   (q_cnt),
    .ddram_addr       (q_addr),
    .ddram_rd         (q_rd & sel),
    .ddram_we         (q_we & sel),
    .ddram_din        (q_din),
    .ddram_be         (q_be),
    .ddram_dout       (b_dout),
    .ddram_dout_ready (b_rdy),
    .st_addr          (q_st),
    .st_dout          (b_st)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers n write beats, holding each while busy; later beats carry junk addr/count.
  task automatic do_write(input logic [28:0] addr, input logic [7:0] cnt, input int n,
                          input logic [7:0] be);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      q_we  = 1'b1;
      q_din = wdata[i];
      q_be  = be;
      if (i == 0) begin
        q_addr = addr;
        q_cnt  = cnt;
      end else begin
        q_addr = 29'h1FFF_FFFF;
        q_cnt  = 8'hAA;
      end
      guard = 0;
      while (busy_s && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      chk("wr_accept", 64'(busy_s), 64'd0);
    end
    @(negedge clk);
    q_we = 1'b0;
  endtask

  // Issues a read and checks the exact beat timing and data against edata.
  task automatic do_read(input string tag, input logic [28:0] addr, input logic [7:0] cnt,
                         input int n, input bit chk_idle);
    int guard;
    @(negedge clk);
    q_rd   = 1'b1;
    q_addr = addr;
    q_cnt  = cnt;
    guard  = 0;
    while (busy_s && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept"}, 64'(busy_s), 64'd0);
    @(negedge clk);
    q_rd   = 1'b0;
    q_addr = 29'h1FFF_FFFF;
    q_cnt  = 8'h55;
    for (int k = 1; k <= LAT - 2; k++) begin
      @(negedge clk);
      chk({tag, "_early_rdy"}, 64'(rdy_s), 64'd0);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, "_rdy"}, 64'(rdy_s), 64'd1);
      chk({tag, "_data"}, dout_s, edata[k]);
      chk({tag, "_busy_rd"}, 64'(busy_s), 64'd1);
    end
    @(negedge clk);
    chk({tag, "_rdy_end"}, 64'(rdy_s), 64'd0);
    if (chk_idle) chk({tag, "_busy_end"}, 64'(busy_s), 64'd0);
  endtask

  task automatic do_status(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    q_st = a;
    @(negedge clk);
    chk(tag, 64'(st_s), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int guard;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd1);
    chk("rst_rdy", 64'(a_rdy), 64'd0);
    chk("rst_dout", a_dout, 64'd0);
    chk("rst_st", 64'(a_st), 64'd0);
    rst = 1'b0;
    chk("rst_release_busy", 64'(a_busy), 64'd1);
    @(negedge clk);
    chk("post_rst_busy", 64'(a_busy), 64'd0);

    // 1: single write then single read
    wdata[0] = 64'h0123_4567_89AB_CDEF;
    do_write(29'h10, 8'd1, 1, 8'hFF);
    edata[0] = 64'h0123_4567_89AB_CDEF;
    do_read("t1", 29'h10, 8'd1, 1, 1'b1);
    do_status("t1_rdcnt", 8'd0, 8'd1);
    do_status("t1_wrcnt", 8'd1, 8'd1);
    do_status("t1_state", 8'd3, 8'd0);

    // 2: partial byte enables
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(29'h10, 8'd1, 1, 8'h0F);
    edata[0] = 64'h0123_4567_FFFF_FFFF;
    do_read("t2", 29'h10, 8'd1, 1, 1'b1);

    // 3: wrapping burst of 8
    for (int i = 0; i < 8; i++) wdata[i] = 64'(i);
    do_write(29'd4093, 8'd8, 8, 8'hFF);
    for (int i = 0; i < 8; i++) edata[i] = 64'(i);
    do_read("t3a", 29'd4093, 8'd8, 8, 1'b1);
    for (int i = 0; i < 5; i++) edata[i] = 64'(i + 3);
    do_read("t3b", 29'h1000_0000, 8'd5, 5, 1'b1);
    do_status("t3_rdcnt", 8'd0, 8'd4);
    do_status("t3_wrcnt", 8'd1, 8'd3);

    // 5: simultaneous rd/we, then zero-length read
    @(negedge clk);
    q_rd   = 1'b1;
    q_we   = 1'b1;
    q_addr = 29'h20;
    q_cnt  = 8'd1;
    q_din  = 64'hA5A5_5A5A_C3C3_3C3C;
    q_be   = 8'hFF;
    chk("t5_busy", 64'(a_busy), 64'd0);
    @(negedge clk);
    q_rd = 1'b0;
    q_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_rdy", 64'(a_rdy), 64'd0);
    end
    do_status("t5_err1", 8'd2, 8'd1);
    edata[0] = 64'hA5A5_5A5A_C3C3_3C3C;
    do_read("t5a", 29'h20, 8'd1, 1, 1'b1);
    do_read("t5b", 29'h20, 8'd0, 1, 1'b1);
    do_status("t5_err2", 8'd2, 8'd2);
    do_status("t5_rdcnt", 8'd0, 8'd6);
    do_status("t5_wrcnt", 8'd1, 8'd4);

    // 4: injected stalls on the BUSY_GAP=5 instance
    sel = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_busy) cnt++;
    end
    chk("t4_gap_count", 64'(cnt), 64'd2);
    wdata[0] = 64'hDEAD_BEEF_0000_5555;
    do_write(29'h50, 8'd1, 1, 8'hFF);
    for (int i = 0; i < 16; i++) wdata[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
    do_write(29'h40, 8'd16, 16, 8'hFF);
    for (int i = 0; i < 16; i++) edata[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
    edata[16] = 64'hDEAD_BEEF_0000_5555;
    do_read("t4", 29'h40, 8'd17, 17, 1'b0);
    do_status("t4_wrcnt", 8'd1, 8'd2);
    do_status("t4_err", 8'd2, 8'd0);
    sel = 1'b0;

    // 6: reset in the middle of a 32-beat read
    @(negedge clk);
    q_rd   = 1'b1;
    q_addr = 29'h10;
    q_cnt  = 8'd32;
    chk("t6_accept", 64'(a_busy), 64'd0);
    @(negedge clk);
    q_rd  = 1'b0;
    guard = 0;
    while (!a_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_first_rdy", 64'(a_rdy), 64'd1);
    chk("t6_first_data", a_dout, 64'h0123_4567_FFFF_FFFF);
    @(negedge clk);
    chk("t6_second_rdy", 64'(a_rdy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_rdy", 64'(a_rdy), 64'd0);
    chk("t6_rst_busy", 64'(a_busy), 64'd1);
    chk("t6_rst_dout", a_dout, 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    q_st = 8'd3;
    chk("t6_release_busy", 64'(a_busy), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_no_more_beats", 64'(a_rdy), 64'd0);
    end
    chk("t6_idle_busy", 64'(a_busy), 64'd0);
    chk("t6_state", 64'(a_st), 64'd0);
    edata[0] = 64'h0123_4567_FFFF_FFFF;
    do_read("t6", 29'h10, 8'd1, 1, 1'b1);
    do_status("t6_rdcnt", 8'd0, 8'd1);
    do_status("t6_err", 8'd2, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
